// File: rtl/branch_predictor_pkg.sv
// Shared constants for the fetch-side branch predictor: counter encodings,
// PC stride and default table geometry.
package branch_predictor_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [31:0] PC_INCR = 32'd4;

    localparam int DEF_INDEX_BITS = 4;
    localparam int DEF_TAG_BITS   = 8;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating counter next-state function used on the table update path.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       taken,
    output logic [1:0] next
);

    always_comb begin
        next = cur;
        if (taken) begin
            if (cur != ST)
                next = cur + 2'd1;
        end else begin
            if (cur != SNT)
                next = cur - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped predictor: 2-bit counter + target per entry, looked up at IF,
// checked and trained from the resolved branch in EX.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int TAG_BITS   = DEF_TAG_BITS
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        IF_Valid,
    input  logic [31:0] IF_PC,
    output logic        Pred_Taken,
    output logic [31:0] Pred_Target,
    input  logic        EX_Valid,
    input  logic        EX_IsBranch,
    input  logic [31:0] EX_PC,
    input  logic        EX_Taken,
    input  logic [31:0] EX_Target,
    input  logic        EX_PredTaken,
    input  logic [31:0] EX_PredTarget,
    output logic        Mispredict,
    output logic [31:0] Redirect_PC,
    output logic [15:0] BranchCount,
    output logic [15:0] MispredictCount
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_LO  = INDEX_BITS + 2;
    localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_BITS-1:0] tag_q [ENTRIES];
    logic [31:0]         tgt_q [ENTRIES];
    logic [1:0]          ctr_q [ENTRIES];

    logic [INDEX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_BITS-1:0]   if_tag, ex_tag;
    logic                  if_hit, ex_hit;
    logic                  ex_branch, ex_alias;
    logic [1:0]            ctr_next;

    assign if_idx = IF_PC[INDEX_BITS+1:2];
    assign if_tag = IF_PC[TAG_HI:TAG_LO];
    assign ex_idx = EX_PC[INDEX_BITS+1:2];
    assign ex_tag = EX_PC[TAG_HI:TAG_LO];

    // Lookup reads registered state only, so a same-cycle update is not seen.
    assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign Pred_Taken  = IF_Valid && if_hit && ctr_q[if_idx][1];
    assign Pred_Target = Pred_Taken ? tgt_q[if_idx] : IF_PC + PC_INCR;

    assign ex_branch = EX_Valid && EX_IsBranch;
    assign ex_alias  = EX_Valid && !EX_IsBranch && EX_PredTaken;
    assign ex_hit    = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    assign Mispredict = (ex_branch && ((EX_Taken != EX_PredTaken) ||
                                       (EX_Taken && (EX_Target != EX_PredTarget))))
                        || ex_alias;
    assign Redirect_PC = (EX_IsBranch && EX_Taken) ? EX_Target : EX_PC + PC_INCR;

    sat_counter2 u_sat (
        .cur   (ctr_q[ex_idx]),
        .taken (EX_Taken),
        .next  (ctr_next)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            valid_q         <= '0;
            BranchCount     <= '0;
            MispredictCount <= '0;
            for (int i = 0; i < ENTRIES; i++)
                ctr_q[i] <= WNT;
        end else begin
            if (ex_branch) begin
                BranchCount <= BranchCount + 16'd1;
                if (ex_hit) begin
                    ctr_q[ex_idx] <= ctr_next;
                end else if (EX_Taken) begin
                    valid_q[ex_idx] <= 1'b1;
                    ctr_q[ex_idx]   <= WT;
                end
            end else if (ex_alias) begin
                valid_q[ex_idx] <= 1'b0;
            end
            if (Mispredict)
                MispredictCount <= MispredictCount + 16'd1;
        end
    end

    // Tag/target payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge Clk) begin
        if (ex_branch && EX_Taken) begin
            tgt_q[ex_idx] <= EX_Target;
            if (!ex_hit)
                tag_q[ex_idx] <= ex_tag;
        end
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{IF_PC[31:TAG_HI+1], IF_PC[1:0], EX_PC[31:TAG_HI+1], EX_PC[1:0]};

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side partner to the EX-stage branch logic interpreter: predicts branches at IF, then checks the resolved branch decision from EX and updates its tables.
- Holds a direct-mapped table that pairs a 2-bit saturating counter with a branch target entry for each index.
- Raises Mispredict with a corrected PC so the pipeline can flush IF/ID and redirect.

Parameters:
- INDEX_BITS, 4, log2 of table entries (16 entries).
- TAG_BITS, 8, PC tag bits stored per entry.

Ports:
- Clk  input  1  clock; all state updates on rising edge
- Reset  input  1  asynchronous, active-low reset
- IF_Valid  input  1  IF_PC holds a real fetch
- IF_PC  input  32  fetch PC (word aligned)
- Pred_Taken  output  1  prediction for IF_PC
- Pred_Target  output  32  next fetch PC
- EX_Valid  input  1  EX slot holds a real, non-squashed instruction
- EX_IsBranch  input  1  EX instruction is a conditional branch
- EX_PC  input  32  PC of the EX instruction
- EX_Taken  input  1  resolved decision (Branch_out of the interpreter)
- EX_Target  input  32  computed branch target
- EX_PredTaken  input  1  Pred_Taken carried down the pipe with this instruction
- EX_PredTarget  input  32  Pred_Target carried down the pipe
- Mispredict  output  1  flush request for the current cycle
- Redirect_PC  output  32  corrected fetch PC, valid while Mispredict=1
- BranchCount  output  16  resolved branches since reset
- MispredictCount  output  16  mispredictions since reset

Behaviour:
- Index = PC[INDEX_BITS+1:2]. Tag = PC[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2].
- Reset (asynchronous, active-low):
  - All Valid bits = 0.
  - All counters = 2'b01 (weakly not-taken).
  - Both count outputs = 0.
  - Since every entry is invalid, Pred_Taken=0 and Pred_Target=IF_PC+4 during and after reset.
- Lookup (combinational from registered table, zero latency):
  - hit = Valid[idx] & Tag[idx]==IF_PC tag.
  - Pred_Taken = IF_Valid & hit & Counter[idx][1].
  - Pred_Target = Pred_Taken ? Target[idx] : IF_PC+4.
- Resolution (combinational, same cycle as EX):
  - Branch case (EX_Valid & EX_IsBranch): Mispredict=1 if EX_Taken!=EX_PredTaken, or if EX_Taken and EX_Target!=EX_PredTarget.
  - Alias case (EX_Valid & !EX_IsBranch & EX_PredTaken): Mispredict=1.
  - Redirect_PC = (EX_IsBranch & EX_Taken) ? EX_Target : EX_PC+4. When Mispredict=0, Redirect_PC is don't-care.
  - Mispredict=0 whenever EX_Valid=0.
- Update (rising edge, from the EX entry at EX_PC index):
  - Branch, tag hit:
    - Counter increments toward 11 if taken, decrements toward 00 if not.
    - Saturates at 11 and 00; no wrap.
    - If taken, Target is rewritten with EX_Target.
  - Branch, tag miss, taken: allocate the entry with Valid=1, new tag, Target=EX_TARGET, Counter=2'b10.
  - Branch, tag miss, not taken: no table write.
  - Alias case: Valid[idx] cleared.
  - BranchCount increments on every resolved branch; MispredictCount increments on every Mispredict. Both are 16-bit and wrap at 0xFFFF→0x0000.
- Simultaneous IF lookup and EX update to the same index: the lookup returns pre-update contents. There is no bypass.
- Counters and table ignore all X-free inputs while EX_Valid=0.
- Reset asserted mid-operation clears the table immediately. Mispredict falls to 0 only through EX_Valid; the pipeline squashes EX on reset.

Decomposition:
- Shared package (included header):
  - Counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - PC_INCR=32'd4.
  - Default INDEX_BITS/TAG_BITS.
- One sub-module, sat_counter2: 2-bit saturating next-state function (inputs cur, taken; output next). It is combinational and instanced once in the update path.
- The table itself stays in branch_predictor as register arrays.

Test Plan:
- Reset with IF_PC=0x0040 → Pred_Taken=0, Pred_Target=0x0044. Resolve a taken branch at EX_PC=0x0040 with EX_Target=0x0080 and EX_PredTaken=0 → Mispredict=1, Redirect_PC=0x0080, MispredictCount=1. Next cycle, IF_PC=0x0040 → Pred_Taken=1, Pred_Target=0x0080.
- After that allocation (counter=10): resolve not-taken at 0x0040 with EX_PredTaken=1 → Mispredict=1, Redirect_PC=0x0044. Counter becomes 01, so the next lookup gives Pred_Taken=0.
- Saturation: 4 taken resolutions at 0x0040 bring the counter to 11. One not-taken gives 10, so Pred_Taken stays 1. A second not-taken gives 01, so Pred_Taken=0.
- Aliasing: entry set at 0x0040, then IF_PC=0x0440 (same index, different tag) → miss, Pred_Taken=0. A non-branch at 0x0040 with EX_PredTaken=1 → Mispredict=1, Redirect_PC=0x0044, entry invalidated.
- Correct prediction: taken branch with EX_PredTaken=1 and EX_PredTarget=EX_Target=0x0100 → Mispredict=0, BranchCount increments, MispredictCount unchanged. With EX_Valid=0 and EX_IsBranch=1 → no count change, no table write.
- Same-cycle hazard: EX allocates index 0 while IF_PC matches it → Pred_Taken=0 that cycle and 1 the following cycle. Asserting Reset=0 mid-sequence → all entries invalid, counts=0 asynchronously.
